tdc_meas_ctrl: RTL and testbench

Measurement controller at the initiating end of the TDC handshake. It issues launch requests to the TDC core on `val_in`/`pg_tog` and enables the core on `en`. It then collects the Hamming-weight results returned on `hw`/`val_out` and accumulates a burst of 2^LOG2_SAMPLES samples into sum, mean, min and max. The summary is presented to the host side on a valid/ready result port.

---
 rtl/tdc_meas_ctrl.sv | 156 +++++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement controller: launches 2^LOG2_SAMPLES TDC conversions per burst and
// reduces the returned Hamming weights to sum/mean/min/max for a valid/ready host port.
module tdc_meas_ctrl #(
    parameter int N            = 64,
    parameter int HW_W         = $clog2(N) + 1,
    parameter int LOG2_SAMPLES = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         tdc_en,
    output logic                         tdc_val_in,
    output logic                         tdc_pg_tog,
    input  logic [HW_W-1:0]              tdc_hw,
    input  logic                         tdc_val_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [HW_W+LOG2_SAMPLES-1:0] res_sum,
    output logic [HW_W-1:0]              res_mean,
    output logic [HW_W-1:0]              res_min,
    output logic [HW_W-1:0]              res_max,
    output logic [LOG2_SAMPLES:0]        res_count,
    output logic                         res_timeout
);

    // state  | meaning
    // IDLE   | waiting for start, result port empty
    // LAUNCH | one-cycle launch pulse to the TDC core
    // WAIT   | waiting for tdc_val_out, timeout down-counter running
    // DONE   | result presented, waiting for res_ready
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int SUM_W = HW_W + LOG2_SAMPLES;
    localparam int CNT_W = LOG2_SAMPLES + 1;
    localparam logic [CNT_W-1:0] NUM_SAMPLES = {1'b1, {LOG2_SAMPLES{1'b0}}};
    localparam logic [15:0]      TMO_LOAD    = 16'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [15:0]      r_tmo_cnt;
    logic             r_busy;
    logic             r_tdc_en;
    logic             r_val_in;
    logic             r_pg_tog;
    logic             r_res_valid;
    logic             r_timeout;
    logic [SUM_W-1:0] r_sum;
    logic [HW_W-1:0]  r_mean;
    logic [HW_W-1:0]  r_min;
    logic [HW_W-1:0]  r_max;
    logic [CNT_W-1:0] r_count;

    logic [SUM_W-1:0] w_sum_acc;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [HW_W-1:0]  w_min_acc;
    logic [HW_W-1:0]  w_max_acc;

    assign w_sum_acc = r_sum + {{LOG2_SAMPLES{1'b0}}, tdc_hw};
    assign w_cnt_inc = r_count + 1'b1;
    assign w_min_acc = (tdc_hw < r_min) ? tdc_hw : r_min;
    assign w_max_acc = (tdc_hw > r_max) ? tdc_hw : r_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tmo_cnt   <= '0;
            r_busy      <= 1'b0;
            r_tdc_en    <= 1'b0;
            r_val_in    <= 1'b0;
            r_pg_tog    <= 1'b0;
            r_res_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_sum       <= '0;
            r_mean      <= '0;
            r_min       <= '0;
            r_max       <= '0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_LAUNCH;
                        r_busy    <= 1'b1;
                        r_tdc_en  <= 1'b1;
                        r_val_in  <= 1'b1;
                        r_pg_tog  <= ~r_pg_tog;
                        r_timeout <= 1'b0;
                        r_sum     <= '0;
                        r_mean    <= '0;
                        r_min     <= '1;
                        r_max     <= '0;
                        r_count   <= '0;
                    end
                end
                S_LAUNCH: begin
                    r_state   <= S_WAIT;
                    r_val_in  <= 1'b0;
                    r_tmo_cnt <= TMO_LOAD;
                end
                S_WAIT: begin
                    // A result arriving on the terminal cycle still counts as a sample.
                    if (tdc_val_out) begin
                        r_sum   <= w_sum_acc;
                        r_mean  <= HW_W'(w_sum_acc >> LOG2_SAMPLES);
                        r_count <= w_cnt_inc;
                        r_min   <= w_min_acc;
                        r_max   <= w_max_acc;
                        if (w_cnt_inc == NUM_SAMPLES) begin
                            r_state     <= S_DONE;
                            r_tdc_en    <= 1'b0;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state  <= S_LAUNCH;
                            r_val_in <= 1'b1;
                            r_pg_tog <= ~r_pg_tog;
                        end
                    end else if (r_tmo_cnt == '0) begin
                        r_state     <= S_DONE;
                        r_tdc_en    <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_timeout   <= 1'b1;
                        if (r_count == '0) begin
                            r_min <= '0;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_res_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign tdc_en      = r_tdc_en;
    assign tdc_val_in  = r_val_in;
    assign tdc_pg_tog  = r_pg_tog;
    assign res_valid   = r_res_valid;
    assign res_timeout = r_timeout;
    assign res_sum     = r_sum;
    assign res_mean    = r_mean;
    assign res_min     = r_min;
    assign res_max     = r_max;
    assign res_count   = r_count;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Scoreboard bench for tdc_meas_ctrl: a TDC responder model feeds planned samples,
// expected burst summaries are queued at stimulus time and checked on each handshake.
module tb_tdc_meas_ctrl;

    localparam int N       = 64;
    localparam int HW_W    = 7;
    localparam int L2S     = 4;
    localparam int NS      = 16;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, tdc_en, tdc_val_in, tdc_pg_tog;
    logic [HW_W-1:0]   tdc_hw = '0;
    logic              tdc_val_out = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [HW_W+L2S-1:0] res_sum;
    logic [HW_W-1:0]   res_mean, res_min, res_max;
    logic [L2S:0]      res_count;
    logic              res_timeout;

    tdc_meas_ctrl #(.N(N), .HW_W(HW_W), .LOG2_SAMPLES(L2S), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .tdc_en(tdc_en),
        .tdc_val_in(tdc_val_in), .tdc_pg_tog(tdc_pg_tog), .tdc_hw(tdc_hw),
        .tdc_val_out(tdc_val_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_mean(res_mean), .res_min(res_min), .res_max(res_max),
        .res_count(res_count), .res_timeout(res_timeout)
    );

    typedef struct {
        int sum; int mean; int mn; int mx; int cnt; bit tmo; int launches; bit pg;
    } exp_t;

    exp_t sb_q[$];
    int   q_plan[$];
    int   launch_cyc[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   launch_cnt = 0;
    int   resp_left = 0;
    int   resp_dmin = 3;
    int   resp_dmax = 3;
    int   last_resp_cyc = 0;
    bit   clr_pending = 1'b0;
    bit   pg_model = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({busy, tdc_en, tdc_val_in, tdc_pg_tog, res_valid, res_timeout,
                    res_sum, res_mean, res_min, res_max, res_count});
    endfunction

    // TDC core stand-in: answers each launch after a random delay while responses remain.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (clr_pending) begin tdc_val_out = 1'b0; clr_pending = 1'b0; end
            if (rst_n && tdc_val_in) begin
                launch_cnt++;
                launch_cyc.push_back(cyc);
                if (resp_left > 0) begin
                    resp_left--;
                    d = $urandom_range(resp_dmax, resp_dmin);
                    repeat (d) @(negedge clk);
                    tdc_hw = HW_W'(q_plan.pop_front());
                    tdc_val_out = 1'b1;
                    last_resp_cyc = cyc;
                    clr_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid && res_ready) begin
                hs_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", res_valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_sum", res_sum, e.sum);
                    chk("res_mean", res_mean, e.mean);
                    chk("res_min", res_min, e.mn);
                    chk("res_max", res_max, e.mx);
                    chk("res_count", res_count, e.cnt);
                    chk("res_timeout", res_timeout, e.tmo);
                    chk("launch_count", launch_cnt, e.launches);
                    chk("pg_tog", tdc_pg_tog, e.pg);
                end
            end
        end
    end

    function automatic exp_t model(input int nresp);
        exp_t e;
        int items;
        items = (nresp < NS) ? nresp : NS;
        e.sum = 0; e.mn = 0; e.mx = 0;
        for (int i = 0; i < items; i++) begin
            e.sum += q_plan[i];
            if (i == 0 || q_plan[i] < e.mn) e.mn = q_plan[i];
            if (q_plan[i] > e.mx) e.mx = q_plan[i];
        end
        e.mean = e.sum / NS;
        e.cnt = items;
        e.tmo = (nresp < NS);
        e.launches = e.tmo ? items + 1 : NS;
        pg_model = pg_model ^ bit'(e.launches % 2);
        e.pg = pg_model;
        return e;
    endfunction

    task automatic bp_phase();
        logic [63:0] snap;
        int lc;
        bit stable;
        snap = out_vec();
        lc = launch_cnt;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start = (i == 3);
            tdc_hw = 7'd5;
            tdc_val_out = (i == 5);
            @(negedge clk);
            if (out_vec() !== snap) stable = 1'b0;
        end
        start = 1'b0;
        tdc_val_out = 1'b0;
        chk("bp_outputs_stable", stable, 1);
        chk("bp_no_new_launch", launch_cnt, lc);
        @(posedge clk); #1 res_ready = 1'b1;
    endtask

    task automatic run_burst(input int nresp, input bit rand_ready, input bit hold);
        exp_t e;
        int t0, guard, done_cyc;
        bit seen, held;
        e = model(nresp);
        sb_q.push_back(e);
        launch_cnt = 0;
        launch_cyc.delete();
        resp_left = nresp;
        res_ready = !hold;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("start_to_launch", {busy, tdc_en, tdc_val_in}, 3'b111);
        t0 = hs_cnt; guard = 0; seen = 0; held = 0; done_cyc = 0;
        while (hs_cnt == t0 && guard < 3000) begin
            @(posedge clk); #1;
            if (rand_ready) res_ready = 1'($urandom_range(1, 0));
            @(negedge clk);
            guard++;
            if (res_valid && !seen) begin seen = 1'b1; done_cyc = cyc; end
            if (hold && seen && !held) begin held = 1'b1; bp_phase(); end
        end
        chk("handshake_count", hs_cnt - t0, 1);
        if (seen && e.tmo && launch_cyc.size() > 0)
            chk("timeout_latency", done_cyc - launch_cyc[launch_cyc.size()-1], TIMEOUT + 1);
        else if (seen && !e.tmo)
            chk("done_latency", done_cyc - last_resp_cyc, 1);
        @(posedge clk); #1 res_ready = 1'b1;
        @(negedge clk);
        chk("post_handshake_idle", {res_valid, busy}, 2'b00);
    endtask

    task automatic reset_mid_wait();
        int guard;
        q_plan.push_back($urandom_range(N, 0));
        q_plan.push_back($urandom_range(N, 0));
        resp_left = 2;
        launch_cnt = 0;
        res_ready = 1'b1;
        resp_dmin = 1; resp_dmax = 3;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        guard = 0;
        while (launch_cnt < 3 && guard < 200) begin @(negedge clk); guard++; end
        chk("reset_reached_wait", launch_cnt, 3);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 chk("async_reset_outputs", out_vec(), 0);
        pg_model = 1'b0;
        launch_cnt = 0;
        q_plan.delete();
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 tdc_hw = 7'd50; tdc_val_out = 1'b1;
        @(posedge clk); #1 tdc_val_out = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_result_ignored", out_vec(), 0);
        chk("late_result_no_launch", launch_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", out_vec(), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        resp_dmin = 3; resp_dmax = 3;
        for (int i = 0; i < NS; i++) q_plan.push_back(32);
        run_burst(NS, 0, 0);

        resp_dmin = 1; resp_dmax = 4;
        for (int i = 0; i < NS; i++) q_plan.push_back(i);
        run_burst(NS, 0, 0);

        for (int i = 0; i < NS; i++) q_plan.push_back(N);
        run_burst(NS, 0, 0);

        for (int i = 0; i < 3; i++) q_plan.push_back($urandom_range(N, 0));
        run_burst(3, 0, 0);

        run_burst(0, 0, 0);

        for (int i = 0; i < NS; i++) q_plan.push_back($urandom_range(N, 0));
        run_burst(NS, 0, 1);

        reset_mid_wait();

        resp_dmin = 1; resp_dmax = 5;
        for (int i = 0; i < NS; i++) q_plan.push_back($urandom_range(N, 0));
        run_burst(NS, 0, 0);

        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < NS; i++) q_plan.push_back($urandom_range(N, 0));
            run_burst(NS, 1, 0);
        end

        k = $urandom_range(15, 1);
        for (int i = 0; i < k; i++) q_plan.push_back($urandom_range(N, 0));
        run_burst(k, 1, 0);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
